bcd_display_mux: RTL

Display stage that consumes the BCD word from the multidigit binary-to-BCD converter and drives a multiplexed common-segment 7-segment display.
- Latches `bcd` on the converter's one-cycle `ready` pulse.
- Scans digits at a prescaled rate.
- Issues one-cycle `load` requests upstream once per scan frame, so the display refreshes continuously.

---
 rtl/bcd_display_mux.sv | 114 +++++++++++
 1 files changed

// File: rtl/bcd_display_mux.sv
// Multiplexed 7-segment display driver fed by a BCD converter; requests a refresh once per frame.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_display_mux #(
   parameter int unsigned nDigits  = 2,
   parameter int unsigned PRESCALE = 1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [nDigits*4-1:0]   bcd,
   input  logic                   ready,
   output logic                   load,
   output logic [6:0]             seg,
   output logic [nDigits-1:0]     an
);

   localparam int unsigned PreW = $clog2(PRESCALE);
   localparam int unsigned DigW = (nDigits > 1) ? $clog2(nDigits) : 1;
   localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);
   localparam logic [DigW-1:0] DigMax = DigW'(nDigits - 1);

   logic [nDigits*4-1:0] disp_q, disp_d;
   logic [PreW-1:0]      pre_cnt_q, pre_cnt_d;
   logic [DigW-1:0]      dig_idx_q, dig_idx_d;
   logic                 pending_q, pending_d;
   logic                 load_q, load_d;
   logic [6:0]           seg_q, seg_d;
   logic [nDigits-1:0]   an_q, an_d;
   logic                 tick, frame_wrap;
   logic [3:0]           cur_digit;
`ifdef LEADING_ZERO_BLANK_EN
   logic                 all_zero;
`endif

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b1000000;
      endcase
      return s;
   endfunction

   always_comb begin
      tick       = (pre_cnt_q == PreMax);
      frame_wrap = tick && (dig_idx_q == DigMax);

      pre_cnt_d = tick ? '0 : pre_cnt_q + PreW'(1);
      dig_idx_d = dig_idx_q;
      if (tick) begin
         dig_idx_d = (dig_idx_q == DigMax) ? '0 : dig_idx_q + DigW'(1);
      end

      disp_d = ready ? bcd : disp_q;

      // A ready coinciding with frame_wrap while pending only clears pending.
      load_d    = frame_wrap && !pending_q;
      pending_d = pending_q;
      if (ready) pending_d = 1'b0;
      if (load_d) pending_d = 1'b1;

      cur_digit = '0;
      an_d      = '0;
      for (int i = 0; i < int'(nDigits); i++) begin
         if (dig_idx_q == DigW'(i)) begin
            cur_digit = disp_q[i*4 +: 4];
            an_d[i]   = 1'b1;
         end
      end
      seg_d = decode(cur_digit);

`ifdef LEADING_ZERO_BLANK_EN
      // Walk down from the top digit; blank while everything at and above is zero.
      all_zero = 1'b1;
      for (int i = int'(nDigits) - 1; i > 0; i--) begin
         all_zero = all_zero && (disp_q[i*4 +: 4] == 4'd0);
         if (all_zero && (dig_idx_q == DigW'(i))) seg_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_q    <= '0;
         pre_cnt_q <= '0;
         dig_idx_q <= '0;
         pending_q <= 1'b0;
         load_q    <= 1'b0;
         seg_q     <= '0;
         an_q      <= '0;
      end else begin
         disp_q    <= disp_d;
         pre_cnt_q <= pre_cnt_d;
         dig_idx_q <= dig_idx_d;
         pending_q <= pending_d;
         load_q    <= load_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign load = load_q;
   assign seg  = seg_q;
   assign an   = an_q;

endmodule
